// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - shared ALU command encoding and widths
package alu_defs;

    localparam int DATA_W    = 32;
    localparam int OVF_CNT_W = 8;

    typedef enum logic [2:0] {
        CMD_ADD  = 3'd0,
        CMD_SUB  = 3'd1,
        CMD_XOR  = 3'd2,
        CMD_SLT  = 3'd3,
        CMD_AND  = 3'd4,
        CMD_NAND = 3'd5,
        CMD_NOR  = 3'd6,
        CMD_OR   = 3'd7
    } alu_cmd_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - request/result handshake bundle of the ALU issue stage
interface alu_issue_stage_if
    import alu_defs::*;
#(
    parameter int TAGW = 4
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [2:0]        in_cmd;
    logic [TAGW-1:0]   in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_carryout;
    logic              out_zero;
    logic              out_overflow;
    logic [TAGW-1:0]   out_tag;

    modport master (
        output in_valid, in_a, in_b, in_cmd, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_carryout, out_zero, out_overflow, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cmd, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_carryout, out_zero, out_overflow, out_tag
    );

endinterface

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU with carry, zero and signed-overflow flags
module alu
    import alu_defs::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        cmd,
    output logic [DATA_W-1:0] result,
    output logic              carryout,
    output logic              zero,
    output logic              overflow
);

    logic              sub;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;
    logic              arith;

    // SUB is a + ~b + 1, so carryout means "no borrow"
    always_comb begin
        sub   = (cmd == CMD_SUB);
        arith = (cmd == CMD_ADD) || (cmd == CMD_SUB);
        b_eff = sub ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub};

        result = '0;
        case (cmd)
            CMD_ADD:  result = sum[DATA_W-1:0];
            CMD_SUB:  result = sum[DATA_W-1:0];
            CMD_XOR:  result = a ^ b;
            CMD_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            CMD_AND:  result = a & b;
            CMD_NAND: result = ~(a & b);
            CMD_NOR:  result = ~(a | b);
            CMD_OR:   result = a | b;
            default:  result = '0;
        endcase

        carryout = arith && sum[DATA_W];
        overflow = arith && (a[DATA_W-1] == b_eff[DATA_W-1])
                         && (sum[DATA_W-1] != a[DATA_W-1]);
        zero     = (result == '0);
    end

endmodule

// File: rtl/alu_req_fifo.sv
// rtl/alu_req_fifo.sv - synchronous request FIFO with occupancy count
module alu_req_fifo #(
    parameter int W     = 71,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push   = push && (count != (AW+1)'(DEPTH));
    assign do_pop    = pop && (count != '0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - buffered, registered front-end for the combinational ALU
module alu_issue_stage
    import alu_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alu_issue_stage_if.slave     bus,
    input  logic                 ovf_clear,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    localparam int ENTRY_W = 2*DATA_W + 3 + TAGW;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic [ENTRY_W-1:0] head;
    logic [CW-1:0]      fifo_count;
    logic               push;
    logic               load;

    logic [DATA_W-1:0]  h_a;
    logic [DATA_W-1:0]  h_b;
    logic [2:0]         h_cmd;
    logic [TAGW-1:0]    h_tag;

    logic [DATA_W-1:0]  alu_result;
    logic               alu_carry;
    logic               alu_zero;
    logic               alu_ovf;

    logic               valid_q;
    logic [DATA_W-1:0]  result_q;
    logic               carry_q;
    logic               zero_q;
    logic               ovf_q;
    logic [TAGW-1:0]    tag_q;

    // Held low through reset so nothing is accepted while state is being cleared
    assign bus.in_ready = reset_n && (fifo_count < CW'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    assign load         = (fifo_count != '0) && (!valid_q || bus.out_ready);

    alu_req_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({bus.in_a, bus.in_b, bus.in_cmd, bus.in_tag}),
        .pop       (load),
        .head_data (head),
        .count     (fifo_count)
    );

    assign {h_a, h_b, h_cmd, h_tag} = head;

    alu u_alu (
        .a        (h_a),
        .b        (h_b),
        .cmd      (h_cmd),
        .result   (alu_result),
        .carryout (alu_carry),
        .zero     (alu_zero),
        .overflow (alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            tag_q    <= '0;
        end else if (load) begin
            valid_q  <= 1'b1;
            result_q <= alu_result;
            carry_q  <= alu_carry;
            zero_q   <= alu_zero;
            ovf_q    <= alu_ovf;
            tag_q    <= h_tag;
        end else if (bus.out_ready) begin
            valid_q  <= 1'b0;
        end
    end

    // Clear wins over a coincident increment
    always_ff @(posedge clk) begin
        if (!reset_n || ovf_clear) begin
            ovf_count <= '0;
        end else if (load && alu_ovf && (ovf_count != '1)) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end

    assign bus.out_valid    = valid_q;
    assign bus.out_result   = result_q;
    assign bus.out_carryout = carry_q;
    assign bus.out_zero     = zero_q;
    assign bus.out_overflow = ovf_q;
    assign bus.out_tag      = tag_q;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered front-end for the 32-bit combinational ALU. Accepts operand/command requests over a valid/ready handshake and buffers them in a small FIFO. Drives the head entry through one ALU instance and holds the result and flags in an output register until the consumer accepts it. Also keeps a saturating count of signed-overflow events for debug and status.

## Interface
Parameters:
- DEPTH, 4: request FIFO entries; power of two, at least 2.
- TAGW, 4: width of the opaque request tag carried alongside each operation.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- reset_n, input, 1: reset is synchronous and active-low.
- in_valid, input, 1: request present.
- in_ready, output, 1: stage can accept a request.
- in_a, input, 32: operandA.
- in_b, input, 32: operandB.
- in_cmd, input, 3: ALU command. ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7.
- in_tag, input, TAGW: returned unchanged with the result.
- out_valid, output, 1: result register holds a valid result.
- out_ready, input, 1: consumer accepts the result.
- out_result, output, 32: ALU result.
- out_carryout, output, 1: carryout flag.
- out_zero, output, 1: zero flag.
- out_overflow, output, 1: signed-overflow flag.
- out_tag, output, TAGW: tag of the result.
- ovf_count, output, 8: saturating count of results delivered with out_overflow=1.
- ovf_clear, input, 1: synchronous clear of ovf_count.

## Operation
- **Push:** a request is pushed when in_valid && in_ready at an edge. in_ready = (fifo_count < DEPTH); there is no same-cycle bypass of a pop.
- **Load:** at an edge where the FIFO is non-empty and (!out_valid || out_ready), the head is popped and the output register loads the ALU outputs plus the tag. out_valid is then 1.
- **Drain:** when out_ready && out_valid and no load occurs, out_valid is cleared. The data fields then hold their last values.
- **Flag masking:** for commands other than ADD and SUB, out_carryout and out_overflow are forced to 0. out_zero is (out_result == 0) for every command.
- **SLT:** the result is 32'h1 or 32'h0, using signed comparison.
- **Overflow counter:** ovf_count increments by 1 on each load with a masked overflow of 1, and saturates at 255. ovf_clear has priority over an increment in the same cycle, so the result is 0.
- **Ordering:** results leave in strict request order; the tag is unchanged.
- **Simultaneous events:**
  - push and pop in the same cycle leave fifo_count unchanged;
  - push into an empty FIFO cannot load in the same edge.
- **Capacity:** with out_ready held low, total capacity is DEPTH+1 requests (FIFO plus output register).

## Timing
- **Latency:** a request accepted at edge E0 appears with out_valid=1 after edge E1 at the earliest (2-cycle latency).
- **Throughput:** one result per cycle sustained when out_ready=1.
- **Reset values:** in_ready 0 while reset_n=0, then 1. out_valid 0. out_result 0. out_carryout, out_zero, out_overflow 0. out_tag 0. ovf_count 0. FIFO empty.
- **Reset mid-operation:** all queued and held requests are discarded; no partial output.
- **Output stability:** outputs are stable while out_valid && !out_ready (standard valid/ready hold rule). in_* are sampled only when in_valid && in_ready.

## Structure
- **Shared package (`alu_defs`):** holds the command encoding constants (ADD…OR), the 32-bit data width, and the 8-bit ovf_count width. The existing ALU and this stage both use it.
- **Sub-module `alu_req_fifo`:** synchronous FIFO of width 32+32+3+TAGW and depth DEPTH, with a count output.
- **ALU:** one instance of the existing combinational ALU, fed from the FIFO head.

## Test plan
- **Reset:** apply reset_n=0 for 2 cycles, then release → all outputs 0, then in_ready=1, ovf_count=0.
- **ADD overflow:** ADD 7FFFFFFF + 7FFFFFFF, tag 3 → after 2 edges out_result=FFFFFFFE, carryout 0, overflow 1, zero 0, tag 3; ovf_count=1.
- **SUB zero:** SUB 00000001 − 00000001 → result 0, carryout 1, zero 1, overflow 0. SUB 80000000 − 70000000 → 10000000, carryout 1, overflow 1.
- **Backpressure:** out_ready=0, offer 6 requests (XOR / AND / OR mix, tags 0–5) → exactly 5 accepted, then in_ready=0. Raise out_ready → results delivered for tags 0–4 in order, one per cycle, with correct values (e.g. XOR 88888888 ^ 11111111 = 99999999, NOR BBBBBBBB,55555555 = 0 with zero=1).
- **SLT and masking:** SLT 80000000 < 05000000 → 1. SLT 05000000 < 80000000 → 0. carryout and overflow are 0 for both.
- **Counter:** 300 overflowing ADDs → ovf_count saturates at 255. ovf_clear asserted in the same cycle as an overflowing load → ovf_count=0. A mid-stream reset while 3 requests are queued → no results emitted afterwards.
